uart_op_responder: RTL and testbench
====================================

Name: uart_op_responder

Overview:
FPGA-side responder for the host operand/result exchange over UART. Collects two operand bytes from the uart_rx byte interface and presents them to the arithmetic core. Captures the core's result and returns it to the host through the uart_tx byte interface. Sits in top_level between uart_rx/uart_tx and the compute unit; also drives the busy/done status LEDs.

Parameters:
TIMEOUT_CYCLES, 100000, max clk cycles allowed between operand A and operand B before the partial frame is discarded
CNT_W, 17, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_done  input  1  one-cycle pulse from uart_rx: rx_data holds a new byte
rx_data  input  8  received byte, valid only when rx_done=1
op_a  output  8  operand A to compute core, held stable from ISSUE until next frame
op_b  output  8  operand B to compute core, held stable from ISSUE until next frame
op_valid  output  1  one-cycle pulse: op_a/op_b valid, start computation
res_valid  input  1  one-cycle pulse from core: res_data valid
res_data  input  8  result byte from core
tx_en  output  1  enable to uart_tx; high while a byte is being sent
tx_data  output  8  byte to uart_tx, stable while tx_en=1
tx_done  input  1  one-cycle pulse from uart_tx: current byte finished
busy  output  1  high in any state other than IDLE
done_flag  output  1  sticky: set when final byte's tx_done seen, cleared on next operand A
timeout_err  output  1  sticky: set on operand-B timeout, cleared on next operand A

Behaviour:
- Reset (reset=0, async): state=IDLE; op_a=op_b=tx_data=0; op_valid=tx_en=busy=done_flag=timeout_err=0; counter=0.
- States: IDLE, WAIT_B, ISSUE, WAIT_RES, SEND, (SEND_CK with option), back to IDLE.
- IDLE: on rx_done, op_a<=rx_data, clear done_flag and timeout_err, counter<=0, -> WAIT_B.
- WAIT_B: counter increments each cycle. On rx_done: op_b<=rx_data, -> ISSUE. Else when counter==TIMEOUT_CYCLES-1: timeout_err<=1, -> IDLE (op_a keeps value, ignored). rx_done on the timeout cycle wins: the byte is accepted as op_b.
- ISSUE: op_valid=1 for exactly one cycle; -> WAIT_RES next cycle.
- WAIT_RES: no timeout. On res_valid: tx_data<=res_data, tx_en<=1, -> SEND. res_valid in any other state is ignored.
- SEND: tx_en held 1, tx_data stable. On tx_done: tx_en<=0, done_flag<=1, -> IDLE (or -> SEND_CK with option, tx_en stays 1, done_flag not yet set).
- rx_done outside IDLE/WAIT_B is dropped (no queuing); the host sends the next frame only after receiving the result.
- Latency: op_valid asserts 2 cycles after the rx_done of operand B (1 cycle to enter ISSUE, registered output). tx_en asserts the cycle after res_valid.
- Reset asserted mid-operation: immediate return to reset values, including tx_en=0 mid-byte; uart_tx is reset by the same signal.
- Counter saturates logic-wise by state exit; no wrap-around possible.

Optional Feature:
CHECKSUM_BYTE_EN: when defined, after the result byte a second byte is sent in SEND_CK: tx_data = op_a XOR op_b XOR result. It is loaded on the result's tx_done with tx_en held continuously high. done_flag sets on the checksum's tx_done. When undefined, SEND_CK does not exist, only the result byte is sent, and done_flag sets on the result's tx_done.

Test Plan:
- Normal frame: rx bytes 0x05 then 0x07; core replies res_valid with 0x0C 5 cycles after op_valid -> op_a=0x05, op_b=0x07, single op_valid pulse, tx_data=0x0C with tx_en high until tx_done, done_flag=1, busy=0.
- Timeout: rx byte 0x05, no further byte for TIMEOUT_CYCLES (set to 20) -> timeout_err=1 after exactly 20 cycles in WAIT_B, no op_valid. Next bytes 0x02, 0x03 -> timeout_err clears, op_valid with op_a=0x02, op_b=0x03.
- Boundary: operand B rx_done on exactly the timeout cycle -> accepted, timeout_err=0, op_valid fires.
- Stray inputs: rx_done (0xFF) during WAIT_RES and res_valid during IDLE -> ignored; op_a/op_b unchanged, no tx_en.
- Reset mid-SEND: assert reset=0 while tx_en=1 -> tx_en, busy, done_flag=0 immediately (async); after release, state is IDLE and a fresh 0x05/0x07 frame completes normally.
- With CHECKSUM_BYTE_EN: operands 0x05, 0x07, result 0x0C -> two bytes sent, 0x0C then 0x0E, tx_en continuous, done_flag only after the second tx_done.

Source files
------------

// File: rtl/uart_op_responder.sv
// rtl/uart_op_responder.sv - UART operand collector and result responder
// Define CHECKSUM_BYTE_EN to append op_a^op_b^result after the result byte.
module uart_op_responder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_valid,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       done_flag,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    ISSUE,
    WAIT_RES,
    SEND
`ifdef CHECKSUM_BYTE_EN
    , SEND_CK
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_op_a;
  logic [7:0]       r_op_b;
  logic [7:0]       r_tx_data;
  logic             r_op_valid;
  logic             r_tx_en;
  logic             r_done_flag;
  logic             r_timeout_err;
  logic             w_cnt_last;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_timeout;
  logic             w_load_res;
  logic             w_load_ck;
  logic             w_finish;

  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    w_timeout  = 1'b0;
    w_load_res = 1'b0;
    w_load_ck  = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      IDLE: if (rx_done) begin
        w_load_a = 1'b1;
        w_next   = WAIT_B;
      end
      // A byte arriving on the last allowed cycle still completes the frame.
      WAIT_B: if (rx_done) begin
        w_load_b = 1'b1;
        w_next   = ISSUE;
      end else if (w_cnt_last) begin
        w_timeout = 1'b1;
        w_next    = IDLE;
      end
      ISSUE: w_next = WAIT_RES;
      WAIT_RES: if (res_valid) begin
        w_load_res = 1'b1;
        w_next     = SEND;
      end
      SEND: if (tx_done) begin
`ifdef CHECKSUM_BYTE_EN
        w_load_ck = 1'b1;
        w_next    = SEND_CK;
`else
        w_finish  = 1'b1;
        w_next    = IDLE;
`endif
      end
`ifdef CHECKSUM_BYTE_EN
      SEND_CK: if (tx_done) begin
        w_finish = 1'b1;
        w_next   = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_op_a        <= 8'h00;
      r_op_b        <= 8'h00;
      r_tx_data     <= 8'h00;
      r_op_valid    <= 1'b0;
      r_tx_en       <= 1'b0;
      r_done_flag   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_op_valid <= (r_state == ISSUE);
      if (r_state == WAIT_B) r_cnt <= r_cnt + CNT_W'(1);
      if (w_load_a) begin
        r_op_a        <= rx_data;
        r_done_flag   <= 1'b0;
        r_timeout_err <= 1'b0;
        r_cnt         <= '0;
      end
      if (w_load_b)  r_op_b        <= rx_data;
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_load_res) begin
        r_tx_data <= res_data;
        r_tx_en   <= 1'b1;
      end
      // tx_data still holds the result here, so it folds into the checksum.
      if (w_load_ck) r_tx_data <= r_op_a ^ r_op_b ^ r_tx_data;
      if (w_finish) begin
        r_tx_en     <= 1'b0;
        r_done_flag <= 1'b1;
      end
    end
  end

  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign op_valid    = r_op_valid;
  assign tx_en       = r_tx_en;
  assign tx_data     = r_tx_data;
  assign busy        = (r_state != IDLE);
  assign done_flag   = r_done_flag;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_op_responder.sv
// tb/tb_uart_op_responder.sv - self-checking bench for uart_op_responder
// Honours CHECKSUM_BYTE_EN when defined for the build.
module tb_uart_op_responder;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = 8'h00;
  logic       tx_done = 1'b0;
  logic [7:0] op_a, op_b, tx_data;
  logic       op_valid, tx_en, busy, done_flag, timeout_err;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         gap;
    int         delay;
    bit         stray;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t vecs[5];

  uart_op_responder #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_valid(res_valid), .res_data(res_data),
    .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .done_flag(done_flag), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (op_valid === 1'b1) ov_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic void model_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    exp_q.delete();
    exp_q.push_back(r);
`ifdef CHECKSUM_BYTE_EN
    exp_q.push_back(a ^ b ^ r);
`endif
  endfunction

  task automatic drain_tx(input string tag);
    bit ok;
    int hold;
    for (int k = 0; k < exp_q.size(); k++) begin
      check({tag, " tx_en"}, {31'd0, tx_en}, 32'd1);
      check({tag, " tx_data"}, {24'd0, tx_data}, {24'd0, exp_q[k]});
      check({tag, " done early"}, {31'd0, done_flag}, 32'd0);
      hold = $urandom_range(0, 3);
      ok = 1'b1;
      repeat (hold) begin
        tick();
        if (tx_en !== 1'b1 || tx_data !== exp_q[k]) ok = 1'b0;
      end
      check({tag, " tx hold"}, {31'd0, ok}, 32'd1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    check({tag, " end tx_en/busy/done"}, {29'd0, tx_en, busy, done_flag}, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                           input int gap, input int delay, input bit stray, input string tag);
    int ov0;
    int lat;
    ov0 = ov_cnt;
    send_rx(a);
    check({tag, " after A busy/done/tmo"}, {29'd0, busy, done_flag, timeout_err}, 32'd4);
    idle(gap);
    send_rx(b);
    lat = 0;
    while (op_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, " op_valid latency"}, lat, 32'd1);
    check({tag, " operands"}, {16'd0, op_a, op_b}, {16'd0, a, b});
    if (stray) send_rx(8'hFF);
    idle(delay);
    res_data  = r;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    drain_tx(tag);
    check({tag, " op_valid pulses"}, ov_cnt - ov0, 32'd1);
    check({tag, " operands held"}, {16'd0, op_a, op_b}, {16'd0, a, b});
  endtask

  initial begin
    int ov0;
    logic [7:0] a, b;

    vecs[0] = '{8'h05, 8'h07, 8'h0C, 0,     5, 1'b0, 8'h0C, 8'h0E};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 3,     0, 1'b0, 8'h00, 8'hFE};
    vecs[2] = '{8'h12, 8'h34, 8'h46, T - 1, 2, 1'b0, 8'h46, 8'h60};
    vecs[3] = '{8'hA5, 8'h5A, 8'hFF, 7,     1, 1'b1, 8'hFF, 8'h00};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1,     3, 1'b1, 8'h00, 8'h00};

    idle(2);
    check("reset outputs", {op_a, op_b, tx_data, 3'd0, op_valid, tx_en, busy, done_flag, timeout_err},
          32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      exp_q.delete();
      exp_q.push_back(vecs[i].exp0);
`ifdef CHECKSUM_BYTE_EN
      exp_q.push_back(vecs[i].exp1);
`endif
      run_frame(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].gap, vecs[i].delay,
                vecs[i].stray, $sformatf("vec%0d", i));
    end

    res_data  = 8'hAA;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    check("stray res_valid in idle", {29'd0, tx_en, busy, done_flag}, 32'd1);

    ov0 = ov_cnt;
    send_rx(8'h05);
    idle(T - 1);
    check("timeout pre busy/tmo", {30'd0, busy, timeout_err}, 32'd2);
    idle(1);
    check("timeout fire busy/tmo", {30'd0, busy, timeout_err}, 32'd1);
    idle(2);
    check("timeout no op_valid", ov_cnt - ov0, 32'd0);
    check("timeout op_a kept", {24'd0, op_a}, 32'h05);
    model_frame(8'h02, 8'h03, 8'h05);
    run_frame(8'h02, 8'h03, 8'h05, 2, 1, 1'b0, "after timeout");

    send_rx(8'h05);
    send_rx(8'h07);
    tick();
    res_data  = 8'h0C;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("rst pre tx_en", {31'd0, tx_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst async outputs", {op_a, op_b, tx_data, 3'd0, op_valid, tx_en, busy, done_flag, timeout_err},
          32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rst release busy", {31'd0, busy}, 32'd0);
    model_frame(8'h05, 8'h07, 8'h0C);
    run_frame(8'h05, 8'h07, 8'h0C, 0, 5, 1'b0, "after reset");

    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      model_frame(a, b, a + b);
      run_frame(a, b, a + b, $urandom_range(0, T - 1), $urandom_range(0, 6),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
